// File: rtl/sipo_deserializer_if.sv
// rtl/sipo_deserializer_if.sv - serial input strobes and parallel word output port of the deserializer
interface sipo_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             shift;
  logic             serial_in;
  logic             frame_start;
  logic             out_ready;
  logic             clear_overrun;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             overrun;
  logic             busy;

  modport master (
    output shift, serial_in, frame_start, out_ready, clear_overrun,
    input  data_out, data_valid, overrun, busy
  );

  modport slave (
    input  shift, serial_in, frame_start, out_ready, clear_overrun,
    output data_out, data_valid, overrun, busy
  );
endinterface

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in/parallel-out receiver with valid/ready word port and sticky overrun
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  sipo_deserializer_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic [WIDTH-1:0] shreg, shreg_next, shreg_base, shifted;
  logic [WIDTH-1:0] data_q, data_next;
  logic             valid_q, valid_next;
  logic             ovr_q, ovr_next;
  logic             complete;
  logic             xfer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
      data_q  <= data_next;
      valid_q <= valid_next;
      ovr_q   <= ovr_next;
    end
  end

  always_comb begin
    // frame_start restarts from an empty register, so a same-edge bit becomes bit 0
    shreg_base = bus.frame_start ? '0 : shreg;
    shifted    = MSB_FIRST ? {shreg_base[WIDTH-2:0], bus.serial_in}
                           : {bus.serial_in, shreg_base[WIDTH-1:1]};
    complete   = bus.shift && !bus.frame_start && (bit_cnt == CNT_W'(WIDTH - 1));
    xfer       = valid_q && bus.out_ready;

    shreg_next   = shreg_base;
    bit_cnt_next = bus.frame_start ? '0 : bit_cnt;
    data_next    = data_q;
    valid_next   = valid_q;
    ovr_next     = ovr_q;
    state_next   = state;

    if (bus.shift) begin
      shreg_next   = shifted;
      bit_cnt_next = complete ? '0 : bit_cnt_next + CNT_W'(1);
    end

    if (xfer) valid_next = 1'b0;
    if (bus.clear_overrun) ovr_next = 1'b0;

    if (complete) begin
      if (!valid_q || bus.out_ready) begin
        data_next  = shifted;
        valid_next = 1'b1;
      end else begin
        ovr_next = 1'b1;
      end
    end

    case (state)
      IDLE: if (bus.shift) state_next = RECV;
      RECV: if (complete || (bus.frame_start && !bus.shift)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state == RECV);
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - directed bench for sipo_deserializer in both bit orders
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic shift = 1'b0, serial_in = 1'b0, frame_start = 1'b0;
  logic out_ready = 1'b0, clear_overrun = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sipo_deserializer_if #(.WIDTH(8)) ifm ();
  sipo_deserializer_if #(.WIDTH(8)) ifl ();

  assign ifm.shift = shift;             assign ifl.shift = shift;
  assign ifm.serial_in = serial_in;     assign ifl.serial_in = serial_in;
  assign ifm.frame_start = frame_start; assign ifl.frame_start = frame_start;
  assign ifm.out_ready = out_ready;     assign ifl.out_ready = out_ready;
  assign ifm.clear_overrun = clear_overrun;
  assign ifl.clear_overrun = clear_overrun;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .reset(reset), .bus(ifm));
  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .reset(reset), .bus(ifl));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    shift = 1'b1;
    serial_in = b;
    tick();
    shift = 1'b0;
  endtask

  // stream order is s[7] first; gap g gives (i % 4) idle cycles after each bit when set
  task automatic send_stream(input logic [7:0] s, input bit g);
    for (int i = 7; i >= 0; i--) begin
      send_bit(s[i]);
      if (g) repeat (i % 4) tick();
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_data", ifm.data_out, 8'h00);
    chk("rst_valid", ifm.data_valid, 1'b0);
    chk("rst_ovr", ifm.overrun, 1'b0);
    chk("rst_busy", ifm.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 1: back-to-back bits, consumer always ready
    out_ready = 1'b1;
    send_bit(1'b1);
    chk("t1_busy_mid", ifm.busy, 1'b1);
    for (int i = 6; i >= 0; i--) send_bit(8'hA5 >> i);
    chk("t1_data", ifm.data_out, 8'hA5);
    chk("t1_valid", ifm.data_valid, 1'b1);
    chk("t1_busy", ifm.busy, 1'b0);
    chk("t1_lsb_data", ifl.data_out, 8'hA5);
    tick();
    chk("t1_valid_drop", ifm.data_valid, 1'b0);

    // 2: gapped bits, consumer stalls then accepts
    out_ready = 1'b0;
    send_stream(8'hA5, 1'b1);
    chk("t2_data", ifm.data_out, 8'hA5);
    chk("t2_valid", ifm.data_valid, 1'b1);
    repeat (3) tick();
    chk("t2_valid_held", ifm.data_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_valid_after", ifm.data_valid, 1'b0);
    chk("t2_data_after", ifm.data_out, 8'hA5);

    // 3: overrun, clear, and set-beats-clear on the same edge
    send_stream(8'h3C, 1'b0);
    chk("t3_first", ifm.data_out, 8'h3C);
    chk("t3_ovr0", ifm.overrun, 1'b0);
    send_stream(8'hF0, 1'b0);
    chk("t3_kept", ifm.data_out, 8'h3C);
    chk("t3_ovr1", ifm.overrun, 1'b1);
    chk("t3_valid", ifm.data_valid, 1'b1);
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    chk("t3_clr", ifm.overrun, 1'b0);
    clear_overrun = 1'b1;
    send_stream(8'h55, 1'b0);
    clear_overrun = 1'b0;
    chk("t3_set_wins", ifm.overrun, 1'b1);
    chk("t3_kept2", ifm.data_out, 8'h3C);
    clear_overrun = 1'b1;
    out_ready = 1'b1;
    tick();
    clear_overrun = 1'b0;
    out_ready = 1'b0;
    chk("t3_drain", ifm.data_valid, 1'b0);
    chk("t3_clr2", ifm.overrun, 1'b0);

    // 4: accept on the same edge a new word completes
    send_stream(8'h11, 1'b0);
    chk("t4_first", ifm.data_out, 8'h11);
    for (int i = 7; i >= 1; i--) send_bit(8'h22 >> i);
    out_ready = 1'b1;
    send_bit(1'b0);
    out_ready = 1'b0;
    chk("t4_data", ifm.data_out, 8'h22);
    chk("t4_valid", ifm.data_valid, 1'b1);
    chk("t4_ovr", ifm.overrun, 1'b0);
    out_ready = 1'b1;
    tick();

    // 5: frame_start with shift restarts the word
    repeat (4) send_bit(1'b1);
    chk("t5_busy", ifm.busy, 1'b1);
    frame_start = 1'b1;
    send_bit(1'b1);
    frame_start = 1'b0;
    chk("t5_no_emit", ifm.data_valid, 1'b0);
    chk("t5_busy_restart", ifm.busy, 1'b1);
    for (int i = 6; i >= 0; i--) send_bit(8'hCC >> i);
    chk("t5_data", ifm.data_out, 8'hCC);
    chk("t5_valid", ifm.data_valid, 1'b1);

    // 6: asynchronous reset mid-word with a pending word, then recovery
    out_ready = 1'b0;
    for (int i = 7; i >= 3; i--) send_bit(8'h81 >> i);
    chk("t6_busy_pre", ifm.busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_data", ifm.data_out, 8'h00);
    chk("t6_rst_valid", ifm.data_valid, 1'b0);
    chk("t6_rst_ovr", ifm.overrun, 1'b0);
    chk("t6_rst_busy", ifm.busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    send_stream(8'h81, 1'b0);
    chk("t6_data", ifm.data_out, 8'h81);
    chk("t6_valid", ifm.data_valid, 1'b1);
    out_ready = 1'b1;
    send_stream(8'hC1, 1'b0);
    chk("t6_msb_c1", ifm.data_out, 8'hC1);
    chk("t6_lsb_c1", ifl.data_out, 8'h83);
    chk("t6_lsb_ovr", ifl.overrun, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
